// File: rtl/fd_queue_pkg.sv
// -----------------------------------------------------------------------------
// fd_queue_pkg
// Shared types and constants for the fetch/decode instruction queue.
//   XLEN_MAX     : widest supported instruction/PC width. Entries are declared
//                  at this width. Narrower builds zero-extend on write, so the
//                  upper bits are constant and are trimmed by synthesis.
//   ARM_PC_OFF4  : offset used to derive PCPlus4D from the stored PC.
//   ARM_PC_OFF8  : offset used to derive PCPlus8D from the stored PC.
//   fd_entry_t   : one queue entry {instr, pc, arm}.
//   make_entry() : packs fetch-side signals into an entry.
// -----------------------------------------------------------------------------
package fd_queue_pkg;

  localparam int XLEN_MAX    = 64;
  localparam int ARM_PC_OFF4 = 4;
  localparam int ARM_PC_OFF8 = 8;

  typedef struct packed {
    logic [XLEN_MAX-1:0] instr;
    logic [XLEN_MAX-1:0] pc;
    logic                arm;
  } fd_entry_t;

  function automatic fd_entry_t make_entry(input logic [XLEN_MAX-1:0] instr,
                                           input logic [XLEN_MAX-1:0] pc,
                                           input logic                arm);
    fd_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.arm   = arm;
    return e;
  endfunction

endpackage

// File: rtl/fd_queue_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Head/tail pointer and occupancy bookkeeping for a circular buffer.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   enq   : request to write at tail (refused when full or flushing)
//   deq   : request to advance head (refused when empty or flushing)
//   flush : clear pointers and count; beats enq and deq
//   full  : count == DEPTH
//   empty : count == 0
//   head  : read pointer
//   tail  : write pointer
//   count : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_ctrl
  import fd_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count
);

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          enq_fire;
  logic          deq_fire;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign enq_fire = enq && !full && !flush;
  assign deq_fire = deq && !empty && !flush;

  // DEPTH is a power of two, so a plain increment wraps DEPTH-1 -> 0.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq_fire) tail_next = tail_reg + PW'(1);
      if (deq_fire) head_next = head_reg + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = count_reg;

endmodule

// File: rtl/fd_queue.sv
// -----------------------------------------------------------------------------
// fd_queue
// Fetch-to-decode instruction queue. Fetch pushes {instr, pc, arm}; decode sees
// the head entry combinationally and pops it unless stalled. A flush empties
// the queue and presents a zero (NOP) bubble in the same cycle.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   arm      : ISA mode of the fetched instruction (1=ARM, 0=RISC-V)
//   EnqF     : fetch offers an instruction
//   RDF      : fetched instruction word
//   PCF      : PC of the fetched instruction
//   ReadyF   : queue has room (CountD < DEPTH)
//   StallD   : decode holds the head entry
//   FlushD   : discard all entries
//   ValidD   : head entry present
//   InstrD   : head instruction (0 when not valid)
//   PCD      : head PC (0 when not valid)
//   PCPlus4D : head PC + 4 (0 when not valid)
//   PCPlus8D : head PC + 8 (0 when not valid)
//   ArmD     : head mode tag (0 when not valid)
//   CountD   : occupancy
// -----------------------------------------------------------------------------
module fd_queue
  import fd_queue_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            EnqF,
  input  logic [XLEN-1:0] RDF,
  input  logic [XLEN-1:0] PCF,
  output logic            ReadyF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [XLEN-1:0] PCPlus8D,
  output logic            ArmD,
  output logic [CW-1:0]   CountD
);

  logic          full;
  logic          empty;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          wr_en;
  fd_entry_t     wr_entry;
  fd_entry_t     slot_bus [DEPTH];
  fd_entry_t     head_entry;
  logic [XLEN-1:0] head_pc;
  logic          unused_head_bits;

  // ReadyF depends only on registered occupancy, never on StallD, so a full
  // queue refuses the enqueue even in a cycle where the head drains.
  assign ReadyF = !full;
  assign ValidD = !empty && !FlushD;
  assign wr_en  = EnqF && ReadyF && !FlushD;

  assign wr_entry = make_entry(XLEN_MAX'(RDF), XLEN_MAX'(PCF), arm);

  fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .enq   (EnqF),
    .deq   (!StallD),
    .flush (FlushD),
    .full  (full),
    .empty (empty),
    .head  (head),
    .tail  (tail),
    .count (CountD)
  );

  // Entry storage: one register per slot, no reset (outputs are masked by
  // ValidD, so stale contents are never visible).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    fd_entry_t slot_reg;

    always_ff @(posedge clk) begin
      if (wr_en && (tail == PW'(gi))) slot_reg <= wr_entry;
    end

    assign slot_bus[gi] = slot_reg;
  end

  assign head_entry = slot_bus[head];
  assign head_pc    = head_entry.pc[XLEN-1:0];

  // Upper entry bits are constant zero when XLEN < XLEN_MAX.
  assign unused_head_bits = ^head_entry;

  // PC+4/PC+8 are derived here rather than stored; addition wraps mod 2^XLEN.
  assign InstrD   = ValidD ? head_entry.instr[XLEN-1:0]   : '0;
  assign PCD      = ValidD ? head_pc                      : '0;
  assign PCPlus4D = ValidD ? head_pc + XLEN'(ARM_PC_OFF4) : '0;
  assign PCPlus8D = ValidD ? head_pc + XLEN'(ARM_PC_OFF8) : '0;
  assign ArmD     = ValidD ? head_entry.arm               : 1'b0;

endmodule

// File: tb/tb_fd_queue.sv
module tb_fd_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            arm = 1'b0;
  logic            EnqF = 1'b0;
  logic [XLEN-1:0] RDF = '0;
  logic [XLEN-1:0] PCF = '0;
  logic            ReadyF;
  logic            StallD = 1'b0;
  logic            FlushD = 1'b0;
  logic            ValidD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [XLEN-1:0] PCPlus8D;
  logic            ArmD;
  logic [CW-1:0]   CountD;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            arm;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  fd_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .EnqF     (EnqF),
    .RDF      (RDF),
    .PCF      (PCF),
    .ReadyF   (ReadyF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .ValidD   (ValidD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .PCPlus8D (PCPlus8D),
    .ArmD     (ArmD),
    .CountD   (CountD)
  );

  // Reference model: a bounded queue of entries; outputs follow from its head.
  function automatic logic m_valid();
    return (mq.size() != 0) && !FlushD;
  endfunction
  function automatic logic m_ready();
    return mq.size() < DEPTH;
  endfunction
  function automatic logic [XLEN-1:0] m_instr();
    return m_valid() ? mq[0].instr : '0;
  endfunction
  function automatic logic [XLEN-1:0] m_pc();
    return m_valid() ? mq[0].pc : '0;
  endfunction
  function automatic logic m_arm();
    return m_valid() ? mq[0].arm : 1'b0;
  endfunction

  // One clock edge: advance the model with the inputs held across the edge.
  task automatic cycle();
    logic rdy;
    logic vld;
    ent_t e;
    rdy = m_ready();
    vld = m_valid();
    e.instr = RDF;
    e.pc    = PCF;
    e.arm   = arm;
    @(posedge clk);
    if (FlushD) begin
      mq.delete();
    end else begin
      if (vld && !StallD) void'(mq.pop_front());
      if (EnqF && rdy) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    EnqF = 1'b0; StallD = 1'b0; FlushD = 1'b0; arm = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ValidD); end
    checks++; if (ReadyF !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", ReadyF); end
    checks++; if (CountD !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", CountD); end
    checks++; if (InstrD !== '0 || PCD !== '0 || PCPlus4D !== '0 || PCPlus8D !== '0 || ArmD !== 1'b0) begin
      errors++; $display("FAIL reset_data: instr %h pc %h pc4 %h pc8 %h arm %0b want all 0", InstrD, PCD, PCPlus4D, PCPlus8D, ArmD);
    end
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset: checked");
  endtask

  task automatic test_basic();
    EnqF = 1'b1; RDF = 32'h0000_0013; PCF = 32'h100; arm = 1'b0;
    cycle();
    EnqF = 1'b0;
    #1;
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", ValidD); end
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL basic_instr: got %h want 00000013", InstrD); end
    checks++; if (PCPlus4D !== 32'h104) begin errors++; $display("FAIL basic_pc4: got %h want 00000104", PCPlus4D); end
    checks++; if (PCPlus8D !== 32'h108) begin errors++; $display("FAIL basic_pc8: got %h want 00000108", PCPlus8D); end
    checks++; if (ArmD !== 1'b0) begin errors++; $display("FAIL basic_arm: got %0b want 0", ArmD); end
    cycle();
    checks++; if (CountD !== '0 || ValidD !== 1'b0) begin errors++; $display("FAIL basic_drain: count %0d valid %0b want 0 0", CountD, ValidD); end
    $display("basic: instr 0x13 pc 0x100 checked");
  endtask

  task automatic test_full_stall();
    StallD = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      EnqF = 1'b1; PCF = 32'(i * 4); RDF = $urandom; arm = 1'($urandom);
      cycle();
    end
    checks++; if (CountD !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d want %0d", CountD, DEPTH); end
    checks++; if (ReadyF !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", ReadyF); end
    PCF = 32'h10; RDF = $urandom;
    cycle();
    checks++; if (CountD !== CW'(DEPTH)) begin errors++; $display("FAIL full_ignore: count %0d want %0d", CountD, DEPTH); end
    EnqF = 1'b0; StallD = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (PCD !== 32'(i * 4) || InstrD !== m_instr() || ArmD !== m_arm()) begin
        errors++; $display("FAIL full_order[%0d]: pc %h instr %h arm %0b want pc %h instr %h arm %0b", i, PCD, InstrD, ArmD, 32'(i * 4), m_instr(), m_arm());
      end
      cycle();
    end
    checks++; if (CountD !== '0) begin errors++; $display("FAIL full_empty: count %0d want 0", CountD); end
    $display("full_stall: fill, refuse 5th, drain in order checked");
  endtask

  task automatic test_full_deq();
    StallD = 1'b1; EnqF = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      PCF = 32'h20 + 32'(i * 4); RDF = $urandom; cycle();
    end
    StallD = 1'b0; PCF = 32'h40;
    cycle();
    checks++; if (CountD !== CW'(DEPTH - 1)) begin errors++; $display("FAIL fulldeq_refuse: count %0d want %0d", CountD, DEPTH - 1); end
    PCF = 32'h44;
    cycle();
    checks++; if (CountD !== CW'(DEPTH - 1)) begin errors++; $display("FAIL fulldeq_accept: count %0d want %0d", CountD, DEPTH - 1); end
    EnqF = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      #1;
      checks++; if (PCD !== m_pc()) begin errors++; $display("FAIL fulldeq_order[%0d]: pc %h want %h", i, PCD, m_pc()); end
      if (i == DEPTH - 2) begin
        checks++; if (PCD !== 32'h44) begin errors++; $display("FAIL fulldeq_last: pc %h want 00000044", PCD); end
      end
      cycle();
    end
    $display("full_deq: refused then accepted, count held checked");
  endtask

  task automatic test_flush();
    StallD = 1'b1; EnqF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCF = 32'h200 + 32'(i * 4); RDF = $urandom | 32'h1; cycle();
    end
    FlushD = 1'b1; PCF = 32'h300; RDF = 32'hDEAD_BEEF;
    #1;
    checks++; if (ValidD !== 1'b0 || InstrD !== '0 || PCD !== '0) begin
      errors++; $display("FAIL flush_bubble: valid %0b instr %h pc %h want 0 0 0", ValidD, InstrD, PCD);
    end
    cycle();
    idle_inputs();
    #1;
    checks++; if (CountD !== '0 || ValidD !== 1'b0) begin errors++; $display("FAIL flush_clear: count %0d valid %0b want 0 0", CountD, ValidD); end
    $display("flush: bubble and clear with concurrent enqueue checked");
  endtask

  task automatic test_stream_wrap();
    EnqF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin PCF = 32'h400 + 32'(i * 4); RDF = $urandom; cycle(); end
    StallD = 1'b0;
    for (int i = 0; i < 10; i++) begin
      PCF = 32'h408 + 32'(i * 4); RDF = $urandom; arm = 1'($urandom);
      #1;
      checks++; if (PCD !== m_pc() || InstrD !== m_instr()) begin
        errors++; $display("FAIL stream_head[%0d]: pc %h instr %h want pc %h instr %h", i, PCD, InstrD, m_pc(), m_instr());
      end
      cycle();
      checks++; if (CountD !== CW'(2)) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 2", i, CountD); end
    end
    drain();
    EnqF = 1'b1; PCF = 32'hFFFF_FFFC; RDF = 32'h1;
    cycle();
    EnqF = 1'b0; #1;
    checks++; if (PCPlus8D !== 32'h4 || PCPlus4D !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: pc4 %h pc8 %h want 00000000 00000004", PCPlus4D, PCPlus8D);
    end
    drain();
    $display("stream_wrap: 10 cycles steady count and PC wrap checked");
  endtask

  task automatic test_async_reset();
    EnqF = 1'b1;
    for (int i = 0; i < 2; i++) begin PCF = 32'h500 + 32'(i * 4); RDF = $urandom; StallD = 1'b1; cycle(); end
    EnqF = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (ValidD !== 1'b0 || CountD !== '0 || ReadyF !== 1'b1) begin
      errors++; $display("FAIL async_reset: valid %0b count %0d ready %0b want 0 0 1", ValidD, CountD, ReadyF);
    end
    mq.delete();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    StallD = 1'b0; EnqF = 1'b1; PCF = 32'h600; RDF = 32'hA5A5_0001; arm = 1'b1;
    cycle();
    EnqF = 1'b0; #1;
    checks++; if (ValidD !== 1'b1 || InstrD !== 32'hA5A5_0001 || PCD !== 32'h600 || ArmD !== 1'b1) begin
      errors++; $display("FAIL post_reset_enq: valid %0b instr %h pc %h arm %0b want 1 a5a50001 00000600 1", ValidD, InstrD, PCD, ArmD);
    end
    drain();
    $display("async_reset: immediate clear and first enqueue after release checked");
  endtask

  task automatic test_random();
    int bad;
    for (int i = 0; i < 400; i++) begin
      EnqF   = ($urandom_range(0, 99) < 60);
      StallD = ($urandom_range(0, 99) < 35);
      FlushD = ($urandom_range(0, 99) < 5);
      arm    = 1'($urandom);
      RDF    = $urandom;
      PCF    = $urandom & 32'hFFFF_FFFC;
      #1;
      bad = 0;
      if (ValidD !== m_valid()) bad++;
      if (ReadyF !== m_ready()) bad++;
      if (CountD !== CW'(mq.size())) bad++;
      if (InstrD !== m_instr()) bad++;
      if (PCD !== m_pc()) bad++;
      if (PCPlus4D !== (m_valid() ? m_pc() + 32'd4 : 32'd0)) bad++;
      if (PCPlus8D !== (m_valid() ? m_pc() + 32'd8 : 32'd0)) bad++;
      if (ArmD !== m_arm()) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random[%0d]: valid %0b ready %0b count %0d instr %h pc %h pc4 %h pc8 %h arm %0b want valid %0b ready %0b count %0d instr %h pc %h arm %0b",
                 i, ValidD, ReadyF, CountD, InstrD, PCD, PCPlus4D, PCPlus8D, ArmD,
                 m_valid(), m_ready(), mq.size(), m_instr(), m_pc(), m_arm());
      end
      cycle();
    end
    idle_inputs();
    $display("random: 400 cycles against reference model");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_stall();
    test_full_deq();
    test_flush();
    test_stream_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_queue.md
FD_QUEUE -- requirements
Module: fd_queue

Interface
REQ-001 Parameter XLEN, 32, instruction/PC width in bits; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, 4, queue entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 arm  input  1  ISA mode at fetch (1=ARM, 0=RISC-V); captured per entry.
REQ-006 EnqF  input  1  fetch offers one instruction this cycle.
REQ-007 RDF  input  XLEN  fetched instruction word.
REQ-008 PCF  input  XLEN  PC of the fetched instruction.
REQ-009 ReadyF  output  1  queue can accept an entry; SHALL equal (CountD < DEPTH).
REQ-010 StallD  input  1  decode holds the head entry.
REQ-011 FlushD  input  1  discard all entries.
REQ-012 ValidD  output  1  head entry present.
REQ-013 InstrD  output  XLEN  head instruction; 0 when not valid.
REQ-014 PCD, PCPlus4D, PCPlus8D  output  XLEN each  head PC, PC+4, PC+8; all 0 when not valid.
REQ-015 ArmD  output  1  mode tag of head entry; 0 when not valid.
REQ-016 CountD  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-017 Circular buffer; head/tail pointers of $clog2(DEPTH) bits SHALL wrap from DEPTH-1 to 0.
REQ-018 Enqueue SHALL occur at an edge when EnqF && ReadyF && !FlushD; it writes {RDF, PCF, arm} at the tail and advances the tail.
REQ-019 EnqF while ReadyF=0 SHALL be ignored; no entry is overwritten.
REQ-020 Dequeue SHALL occur at an edge when ValidD && !StallD && !FlushD; the head advances.
REQ-021 Simultaneous enqueue and dequeue SHALL leave CountD unchanged.
REQ-022 Full queue plus dequeue: the enqueue SHALL still be refused that cycle (ReadyF has no combinational path from StallD).
REQ-023 Latency: an entry enqueued into an empty queue at edge n SHALL appear on ValidD/InstrD after edge n. There is no same-cycle bypass.
REQ-024 Outputs SHALL be combinational from the head entry plus ValidD; ValidD = (CountD != 0) && !FlushD.
REQ-025 While FlushD=1, InstrD/PC outputs SHALL be 0, giving a NOP bubble.
REQ-026 At an edge with FlushD=1, both pointers and CountD SHALL go to 0; a concurrent enqueue SHALL be discarded. FlushD has priority over StallD and EnqF.
REQ-027 PCPlus4D/PCPlus8D SHALL be computed from the stored PC modulo 2^XLEN; PC+4 is not stored.
REQ-028 StallD with an empty queue SHALL have no effect.

Reset
REQ-029 rst low SHALL immediately clear pointers and CountD. Consequently ValidD=0, ReadyF=1, and all data outputs are 0.
REQ-030 Entry storage SHALL need no reset; outputs are masked by ValidD.
REQ-031 Reset asserted mid-operation SHALL discard all entries. The first enqueue after release SHALL be accepted normally.

Structure
REQ-032 A shared package SHALL hold the entry struct {instr, pc, arm}, parameterised by XLEN, plus the ARM PC offset constants 4 and 8.
REQ-033 Pointer/count logic SHALL be a sub-module fifo_ctrl (parameter DEPTH; ports: enq, deq, flush, full, empty, head, tail, count). fd_queue holds storage and the output datapath.

Verification
REQ-034 Reset, then enqueue 0x00000013 @PC 0x100 with arm=0 -> next cycle ValidD=1, InstrD=0x13, PCPlus4D=0x104, PCPlus8D=0x108, ArmD=0.
REQ-035 StallD=1, enqueue PCs 0x0,0x4,0x8,0xC (DEPTH=4) -> CountD=4, ReadyF=0. A 5th EnqF is ignored; after releasing StallD, outputs PCs 0x0..0xC in order.
REQ-036 Full queue, StallD=0, EnqF=1 for one cycle -> CountD becomes 3, no enqueue. Next cycle the enqueue is accepted and CountD stays 3.
REQ-037 Queue with 3 entries, FlushD=1 with EnqF=1 -> same cycle ValidD=0, InstrD=0. Next cycle CountD=0 and the enqueued entry is lost.
REQ-038 Continuous enqueue and dequeue for 10 cycles -> tail/head wrap correctly and CountD stays constant. PC 0xFFFFFFFC -> PCPlus8D=0x4 (XLEN=32).
REQ-039 rst low asynchronously mid-stream (between edges) -> ValidD=0 and CountD=0 immediately.
